// File: rtl/dft4_loader_if.sv
// Stream-in / frame-out bundle for the DFT_4 input loader.
// Optional s_last/err_align exist only when DFT4_LOADER_LAST_EN is defined.
interface dft4_loader_if #(
  parameter int unsigned N = 32
);
  logic         flush;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_re;
  logic [N-1:0] s_im;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] ar, ai, br, bi, cr, ci, dr, di;
  logic [1:0]   fill_idx;
`ifdef DFT4_LOADER_LAST_EN
  logic         s_last;
  logic         err_align;
`endif

  // Environment side: produces samples, consumes frames
  modport master (
    output flush, s_valid, s_re, s_im, m_ready,
    input  s_ready, m_valid, ar, ai, br, bi, cr, ci, dr, di, fill_idx
`ifdef DFT4_LOADER_LAST_EN
    , output s_last
    , input  err_align
`endif
  );

  // Loader side
  modport slave (
    input  flush, s_valid, s_re, s_im, m_ready,
    output s_ready, m_valid, ar, ai, br, bi, cr, ci, dr, di, fill_idx
`ifdef DFT4_LOADER_LAST_EN
    , input  s_last
    , output err_align
`endif
  );
endinterface

// File: rtl/dft4_input_loader.sv
// Ping-pong loader packing a serial complex stream into 4-sample frames for DFT_4.
// Optional macro DFT4_LOADER_LAST_EN adds s_last framing with zero-fill and err_align.
module dft4_input_loader #(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dft4_loader_if.slave   bus
);
  localparam int unsigned NSLOT = 4;

  logic [N-1:0] r_re [2][NSLOT];
  logic [N-1:0] r_im [2][NSLOT];
  logic [1:0]   r_full;
  logic         r_wr_bank;
  logic         r_rd_bank;
  logic [1:0]   r_idx;

  logic         w_s_ready;
  logic         w_m_valid;
  logic         w_accept;
  logic         w_drain;
  logic         w_close;
  logic [1:0]   w_full_nxt;

  assign w_s_ready = !r_full[r_wr_bank];
  assign w_m_valid = r_full[r_rd_bank];
  assign w_accept  = bus.s_valid && w_s_ready;
  assign w_drain   = w_m_valid && bus.m_ready;

`ifdef DFT4_LOADER_LAST_EN
  logic r_err_align;
  assign w_close       = w_accept && ((r_idx == 2'd3) || bus.s_last);
  assign bus.err_align = r_err_align;

  // Misaligned frame end: count reached 4 without s_last, or s_last came early
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_align <= 1'b0;
    end else if (bus.flush) begin
      r_err_align <= 1'b0;
    end else begin
      r_err_align <= w_accept && ((r_idx == 2'd3) != bus.s_last);
    end
  end
`else
  assign w_close = w_accept && (r_idx == 2'd3);
`endif

  // Completion and drain always touch different banks, so both may apply
  always_comb begin
    w_full_nxt = r_full;
    if (w_drain) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_close) w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_idx     <= 2'd0;
    end else if (bus.flush) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_idx     <= 2'd0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) r_idx <= w_close ? 2'd0 : r_idx + 2'd1;
      if (w_close)  r_wr_bank <= ~r_wr_bank;
      if (w_drain)  r_rd_bank <= ~r_rd_bank;
    end
  end

  // Sample storage; slots after an early close are zero-filled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < NSLOT; j++) begin
          r_re[b][j] <= '0;
          r_im[b][j] <= '0;
        end
      end
    end else if (bus.flush) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < NSLOT; j++) begin
          r_re[b][j] <= '0;
          r_im[b][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int j = 0; j < NSLOT; j++) begin
        if (2'(j) == r_idx) begin
          r_re[r_wr_bank][j] <= bus.s_re;
          r_im[r_wr_bank][j] <= bus.s_im;
        end else if (w_close && (2'(j) > r_idx)) begin
          r_re[r_wr_bank][j] <= '0;
          r_im[r_wr_bank][j] <= '0;
        end
      end
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.m_valid  = w_m_valid;
  assign bus.fill_idx = r_idx;
  assign bus.ar = r_re[r_rd_bank][0];
  assign bus.ai = r_im[r_rd_bank][0];
  assign bus.br = r_re[r_rd_bank][1];
  assign bus.bi = r_im[r_rd_bank][1];
  assign bus.cr = r_re[r_rd_bank][2];
  assign bus.ci = r_im[r_rd_bank][2];
  assign bus.dr = r_re[r_rd_bank][3];
  assign bus.di = r_im[r_rd_bank][3];
endmodule

// File: tb/tb_dft4_input_loader.sv
// Randomized + directed bench for dft4_input_loader against a frame-queue model.
// Honours DFT4_LOADER_LAST_EN when defined.
module tb_dft4_input_loader;
  localparam int unsigned N = 32;

  typedef struct packed {
    logic [3:0][N-1:0] re;
    logic [3:0][N-1:0] im;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  dft4_loader_if #(.N(N)) bus ();
  dft4_input_loader #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Model: queue of completed frames waiting for the consumer, plus the partial frame
  frame_t q[$];
  frame_t pre;
  int     pcnt = 0;
  logic   exp_err = 1'b0;
  int     stall_cnt = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic in_last();
`ifdef DFT4_LOADER_LAST_EN
    return bus.s_last;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    frame_t f;
    logic   acc, drn, lst;
    if (!rst_n) begin
      q.delete(); pcnt = 0; pre = '0; exp_err = 1'b0;
    end
    chk("s_ready",  N'(bus.s_ready),  N'(q.size() < 2));
    chk("m_valid",  N'(bus.m_valid),  N'(q.size() > 0));
    chk("fill_idx", N'(bus.fill_idx), N'(pcnt));
`ifdef DFT4_LOADER_LAST_EN
    chk("err_align", N'(bus.err_align), N'(exp_err));
`endif
    if (q.size() > 0) begin
      f = q[0];
      chk("ar", bus.ar, f.re[0]); chk("ai", bus.ai, f.im[0]);
      chk("br", bus.br, f.re[1]); chk("bi", bus.bi, f.im[1]);
      chk("cr", bus.cr, f.re[2]); chk("ci", bus.ci, f.im[2]);
      chk("dr", bus.dr, f.re[3]); chk("di", bus.di, f.im[3]);
    end
    if (rst_n) begin
      if (bus.flush) begin
        q.delete(); pcnt = 0; pre = '0; exp_err = 1'b0;
      end else begin
        acc = bus.s_valid && (q.size() < 2);
        drn = (q.size() > 0) && bus.m_ready;
        lst = in_last();
        exp_err = acc && ((pcnt == 3) != lst);
        if (drn) void'(q.pop_front());
        if (acc) begin
          pre.re[pcnt] = bus.s_re;
          pre.im[pcnt] = bus.s_im;
          pcnt++;
          if (pcnt == 4 || lst) begin
            for (int j = pcnt; j < 4; j++) begin
              pre.re[j] = '0; pre.im[j] = '0;
            end
            q.push_back(pre);
            pre = '0;
            pcnt = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one sample and hold it until the loader takes it (bounded)
  task automatic push(input logic [N-1:0] re, input logic [N-1:0] im);
    logic acc;
    bus.s_valid = 1'b1; bus.s_re = re; bus.s_im = im;
    for (int t = 0; t < 60; t++) begin
      acc = bus.s_ready;
      step();
      if (acc) begin
        bus.s_valid = 1'b0;
        return;
      end
    end
    bus.s_valid = 1'b0;
    chk("push_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_zero_idle(input string tag);
    chk({tag, "_s_ready"}, N'(bus.s_ready), 1);
    chk({tag, "_m_valid"}, N'(bus.m_valid), 0);
    chk({tag, "_fill_idx"}, N'(bus.fill_idx), 0);
    chk({tag, "_ar"}, bus.ar, 0);
    chk({tag, "_di"}, bus.di, 0);
  endtask

  initial begin
    bus.flush = 1'b0; bus.s_valid = 1'b0; bus.s_re = '0; bus.s_im = '0; bus.m_ready = 1'b0;
`ifdef DFT4_LOADER_LAST_EN
    bus.s_last = 1'b0;
`endif
    #12;
    chk_zero_idle("reset");
    rst_n = 1'b1;
    step();

    // Single frame, literal expectations
    bus.m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) push(N'(k), '0);
    chk("single_m_valid", N'(bus.m_valid), 1);
    chk("single_ar", bus.ar, 1);
    chk("single_br", bus.br, 2);
    chk("single_cr", bus.cr, 3);
    chk("single_dr", bus.dr, 4);
    chk("single_ai", bus.ai, 0);
    repeat (3) step();

    // Backpressure: 8 accepted, then stall until consumer releases
    bus.m_ready = 1'b0;
    fork
      for (int k = 1; k <= 12; k++) push(N'(k), N'(-k));
      begin
        repeat (12) step();
        chk("bp_s_ready", N'(bus.s_ready), 0);
        chk("bp_m_valid", N'(bus.m_valid), 1);
        chk("bp_ar", bus.ar, 1);
        chk("bp_ai", bus.ai, N'(-1));
        bus.m_ready = 1'b1;
      end
    join
    repeat (6) step();

    // Continuous streaming, no bubbles
    for (int k = 0; k < 64; k++) begin
      bus.s_valid = 1'b1; bus.s_re = N'(100 + k); bus.s_im = N'(k * 3);
      if (!bus.s_ready) stall_cnt++;
      step();
    end
    bus.s_valid = 1'b0;
    chk("cont_stalls", N'(stall_cnt), 0);
    repeat (3) step();

    // Flush mid-frame
    push(N'(55), N'(66)); push(N'(77), N'(88));
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    chk_zero_idle("flush");
    for (int k = 0; k < 4; k++) push(N'(200 + k), N'(k));
    repeat (3) step();

    // Reset mid-frame
    push(N'(11), N'(12)); push(N'(13), N'(14));
    do_reset();
    chk_zero_idle("rst_mid");
    for (int k = 0; k < 4; k++) push(N'(300 + k), N'(7 * k));
    repeat (3) step();

`ifdef DFT4_LOADER_LAST_EN
    do_reset();
    bus.m_ready = 1'b0;
    push(N'(7), N'(-1));
    bus.s_last = 1'b1; push(N'(8), N'(-2)); bus.s_last = 1'b0;
    chk("last_ar", bus.ar, 7);  chk("last_ai", bus.ai, N'(-1));
    chk("last_br", bus.br, 8);  chk("last_bi", bus.bi, N'(-2));
    chk("last_cr", bus.cr, 0);  chk("last_dr", bus.dr, 0);
    chk("last_err", N'(bus.err_align), 1);
    step();
    chk("last_err_clear", N'(bus.err_align), 0);
    bus.m_ready = 1'b1;
    repeat (3) step();
`endif

    // Randomized traffic with occasional flush
    for (int c = 0; c < 1500; c++) begin
      bus.s_valid = ($urandom_range(0, 9) < 7);
      bus.s_re    = N'($urandom());
      bus.s_im    = N'($urandom());
      bus.m_ready = ($urandom_range(0, 9) < 5);
      bus.flush   = ($urandom_range(0, 99) == 0);
`ifdef DFT4_LOADER_LAST_EN
      bus.s_last  = ($urandom_range(0, 9) == 0);
`endif
      step();
    end
    bus.s_valid = 1'b0; bus.flush = 1'b0; bus.m_ready = 1'b1;
`ifdef DFT4_LOADER_LAST_EN
    bus.s_last = 1'b0;
`endif
    repeat (5) step();
    chk("drained_m_valid", N'(bus.m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
